// File: rtl/spi_bus_arbiter_if.sv
// Bundle of requester, SPI engine and chip-select signals around the
// SPI bus arbiter. The slave modport is the arbiter's view; the master
// modport is the view of everything around it (requesters, engine, pins).
//
// Handshakes, in one place:
//   - reqN is a level: high for the whole session, dropped to end it.
//   - gntN goes high once CE has been set up and stays high while port N
//     owns the bus.
//   - startN is a one-cycle pulse; it is honoured only while gntN is high
//     and no byte is in flight. Any other pulse is discarded.
//   - doneN is a one-cycle pulse; rx_data is valid with it and is held
//     until the next completion.
//   - spi_txn_start is held high until spi_txn_done is seen low (engine
//     busy), then released. spi_txn_done returning high means the byte
//     has completed and spi_data_rx is valid.
interface spi_bus_arbiter_if;
    logic       req0;
    logic       req1;
    logic       tgt0;
    logic       tgt1;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic       start0;
    logic       start1;
    logic       done0;
    logic       done1;
    logic [7:0] rx_data;
    logic [7:0] spi_data_tx;
    logic       spi_txn_start;
    logic       spi_txn_done;
    logic [7:0] spi_data_rx;
    logic       spi_flash_ce_n;
    logic       spi_ram_ce_n;

    modport slave (
        input  req0, req1, tgt0, tgt1, tx0, tx1, start0, start1,
        input  spi_txn_done, spi_data_rx,
        output gnt0, gnt1, done0, done1, rx_data,
        output spi_data_tx, spi_txn_start, spi_flash_ce_n, spi_ram_ce_n
    );

    modport master (
        output req0, req1, tgt0, tgt1, tx0, tx1, start0, start1,
        output spi_txn_done, spi_data_rx,
        input  gnt0, gnt1, done0, done1, rx_data,
        input  spi_data_tx, spi_txn_start, spi_flash_ce_n, spi_ram_ce_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-port arbiter for one SPI byte engine and the flash/RAM chip selects.
// Port 0 is the UART bootloader, port 1 the CPU memory controller.
// Whole CE-bracketed sessions are granted round-robin; CE setup and idle
// times are enforced, and the engine start/done handshake is sequenced
// for the current owner. The last idle cycle also acts as the arbitration
// cycle, so CE stays high for exactly CS_IDLE_CYCLES between sessions
// when a request is already waiting.
module spi_bus_arbiter #(
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_IDLE_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_bus_arbiter_if.slave    bus,
    output logic [2:0]          state_dbg
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_OWNED      = 3'd2;
    localparam logic [2:0] ST_XFER_START = 3'd3;
    localparam logic [2:0] ST_XFER_WAIT  = 3'd4;
    localparam logic [2:0] ST_RELEASE    = 3'd5;

    localparam int MAX_CNT = (CS_SETUP_CYCLES > CS_IDLE_CYCLES) ? CS_SETUP_CYCLES : CS_IDLE_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    // Counters run from N-1 down to 0, so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(CS_IDLE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_winner_q, last_winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             txn_start_q, txn_start_d;
    logic [7:0]       data_tx_q, data_tx_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             flash_ce_n_q, flash_ce_n_d;
    logic             ram_ce_n_q, ram_ce_n_d;

    logic       req_own;
    logic       start_own;
    logic [7:0] tx_own;
    logic       any_req;
    logic       pick;
    logic       pick_tgt;
    logic       do_grant;
    logic       do_release;

    // Owner-side views of the requester inputs and the arbitration choice.
    always_comb begin
        req_own   = owner_q ? bus.req1   : bus.req0;
        start_own = owner_q ? bus.start1 : bus.start0;
        tx_own    = owner_q ? bus.tx1    : bus.tx0;
        any_req   = bus.req0 | bus.req1;
        // Contention goes to the port that did not win last; otherwise
        // the single requester wins.
        pick      = (bus.req0 & bus.req1) ? ~last_winner_q : bus.req1;
        pick_tgt  = pick ? bus.tgt1 : bus.tgt0;
    end

    // Session FSM: next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        done_d        = 2'b00;
        txn_start_d   = txn_start_q;
        data_tx_d     = data_tx_q;
        rx_data_d     = rx_data_q;
        flash_ce_n_d  = flash_ce_n_q;
        ram_ce_n_d    = ram_ce_n_q;
        do_grant      = 1'b0;
        do_release    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_grant = any_req;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_OWNED;
                    gnt_d   = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OWNED: begin
                // A start in the same cycle as the req drop wins; the drop
                // is picked up again after the byte completes.
                if (start_own) begin
                    data_tx_d   = tx_own;
                    txn_start_d = 1'b1;
                    state_d     = ST_XFER_START;
                end else if (!req_own) begin
                    do_release = 1'b1;
                end
            end
            ST_XFER_START: begin
                // The engine signals acceptance by leaving idle.
                if (!bus.spi_txn_done) begin
                    txn_start_d = 1'b0;
                    state_d     = ST_XFER_WAIT;
                end
            end
            ST_XFER_WAIT: begin
                if (bus.spi_txn_done) begin
                    rx_data_d = bus.spi_data_rx;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    if (req_own) begin
                        state_d = ST_OWNED;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    if (any_req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_release) begin
            state_d      = ST_RELEASE;
            gnt_d        = 2'b00;
            flash_ce_n_d = 1'b1;
            ram_ce_n_d   = 1'b1;
            cnt_d        = IDLE_LOAD;
        end

        // The CE flops hold the latched target for the whole session.
        if (do_grant) begin
            state_d       = ST_SETUP;
            owner_d       = pick;
            last_winner_d = pick;
            flash_ce_n_d  = pick_tgt;
            ram_ce_n_d    = ~pick_tgt;
            cnt_d         = SETUP_LOAD;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_winner_q <= 1'b1;
            cnt_q         <= '0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            txn_start_q   <= 1'b0;
            data_tx_q     <= 8'h00;
            rx_data_q     <= 8'h00;
            flash_ce_n_q  <= 1'b1;
            ram_ce_n_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            txn_start_q   <= txn_start_d;
            data_tx_q     <= data_tx_d;
            rx_data_q     <= rx_data_d;
            flash_ce_n_q  <= flash_ce_n_d;
            ram_ce_n_q    <= ram_ce_n_d;
        end
    end

    assign bus.gnt0           = gnt_q[0];
    assign bus.gnt1           = gnt_q[1];
    assign bus.done0          = done_q[0];
    assign bus.done1          = done_q[1];
    assign bus.rx_data        = rx_data_q;
    assign bus.spi_data_tx    = data_tx_q;
    assign bus.spi_txn_start  = txn_start_q;
    assign bus.spi_flash_ce_n = flash_ce_n_q;
    assign bus.spi_ram_ce_n   = ram_ce_n_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a small SPI engine model and a
// safety monitor (mutual-exclusion of grants and chip selects).
module tb_spi_bus_arbiter;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_XFER_WAIT = 3'd4;
    localparam int         ENG_LAT      = 3;

    logic       clk;
    logic       rst;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    spi_bus_arbiter_if bus();

    spi_bus_arbiter #(
        .CS_SETUP_CYCLES(2),
        .CS_IDLE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SPI engine model ----------------
    logic       eng_done;
    int         eng_cnt;
    logic [7:0] eng_rx;
    int         eng_starts    = 0;
    int         eng_completes = 0;

    assign bus.spi_txn_done = eng_done;

    always @(posedge clk) begin
        if (rst) begin
            eng_done        <= 1'b1;
            eng_cnt         <= 0;
            bus.spi_data_rx <= 8'h00;
        end else if (eng_done && bus.spi_txn_start) begin
            eng_done   <= 1'b0;
            eng_cnt    <= ENG_LAT;
            eng_starts <= eng_starts + 1;
        end else if (!eng_done) begin
            if (eng_cnt == 0) begin
                eng_done        <= 1'b1;
                bus.spi_data_rx <= eng_rx;
                eng_completes   <= eng_completes + 1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int viol      = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gnt0 && bus.gnt1) viol <= viol + 1;
            if (!bus.spi_flash_ce_n && !bus.spi_ram_ce_n) viol <= viol + 1;
            if (bus.done0) done0_cnt <= done0_cnt + 1;
            if (bus.done1) done1_cnt <= done1_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.tgt0   = 1'b0;
        bus.tgt1   = 1'b0;
        bus.tx0    = 8'h00;
        bus.tx1    = 8'h00;
        bus.start0 = 1'b0;
        bus.start1 = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (state_dbg !== ST_IDLE && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL wait_idle: state=%0d after %0d cycles, required %0d", state_dbg, n, ST_IDLE);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.spi_txn_start} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl: gnt/done/start=%b required 00000",
                     {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.spi_txn_start});
        end
        checks++;
        if ({bus.spi_flash_ce_n, bus.spi_ram_ce_n} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ce: ce_n=%b required 11", {bus.spi_flash_ce_n, bus.spi_ram_ce_n});
        end
        checks++;
        if (bus.spi_data_tx !== 8'h00 || bus.rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: tx=%h rx=%h required 00 00", bus.spi_data_tx, bus.rx_data);
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_single_session();
        bit got;
        tick();
        bus.req0 = 1'b1;
        bus.tgt0 = 1'b1;
        tick();
        checks++;
        if (bus.spi_ram_ce_n !== 1'b0 || bus.spi_flash_ce_n !== 1'b1 || bus.gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL single_ce: ram_ce_n=%b flash_ce_n=%b gnt0=%b required 0 1 0",
                     bus.spi_ram_ce_n, bus.spi_flash_ce_n, bus.gnt0);
        end
        tick();
        checks++;
        if (bus.gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt_early: gnt0=%b required 0", bus.gnt0);
        end
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
        end
        eng_rx     = 8'hC2;
        bus.tx0    = 8'h9F;
        bus.start0 = 1'b1;
        tick();
        bus.start0 = 1'b0;
        checks++;
        if (bus.spi_data_tx !== 8'h9F || bus.spi_txn_start !== 1'b1) begin
            failures++;
            $display("FAIL single_start: tx=%h start=%b required 9f 1", bus.spi_data_tx, bus.spi_txn_start);
        end
        tick();
        checks++;
        if (bus.spi_txn_start !== 1'b1) begin
            failures++;
            $display("FAIL single_start_hold: start=%b required 1", bus.spi_txn_start);
        end
        tick();
        checks++;
        if (bus.spi_txn_start !== 1'b0) begin
            failures++;
            $display("FAIL single_start_drop: start=%b required 0", bus.spi_txn_start);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (bus.done0 || bus.done1) got = 1'b1;
        end
        checks++;
        if (!got || bus.done0 !== 1'b1 || bus.done1 !== 1'b0 || bus.rx_data !== 8'hC2) begin
            failures++;
            $display("FAIL single_done: seen=%0d done0=%b done1=%b rx=%h required 1 1 0 c2",
                     got, bus.done0, bus.done1, bus.rx_data);
        end
        tick();
        checks++;
        if (bus.done0 !== 1'b0 || bus.rx_data !== 8'hC2 || bus.gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL single_after: done0=%b rx=%h gnt0=%b required 0 c2 1",
                     bus.done0, bus.rx_data, bus.gnt0);
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.spi_ram_ce_n !== 1'b1) begin
            failures++;
            $display("FAIL single_release: gnt0=%b ram_ce_n=%b required 0 1", bus.gnt0, bus.spi_ram_ce_n);
        end
        wait_idle(30);
    endtask

    task automatic test_round_robin();
        int hi;
        do_reset();
        tick();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.tgt0 = 1'b0;
        bus.tgt1 = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.spi_flash_ce_n !== 1'b0 || bus.spi_ram_ce_n !== 1'b1) begin
            failures++;
            $display("FAIL rr_first: gnt0=%b gnt1=%b flash=%b ram=%b required 1 0 0 1",
                     bus.gnt0, bus.gnt1, bus.spi_flash_ce_n, bus.spi_ram_ce_n);
        end
        bus.req0 = 1'b0;
        tick();
        hi = 0;
        for (int i = 0; i < 20 && bus.spi_flash_ce_n && bus.spi_ram_ce_n; i++) begin
            hi++;
            tick();
        end
        checks++;
        if (hi != 4) begin
            failures++;
            $display("FAIL rr_idle_len: ce high %0d cycles required 4", hi);
        end
        checks++;
        if (bus.spi_ram_ce_n !== 1'b0 || bus.spi_flash_ce_n !== 1'b1) begin
            failures++;
            $display("FAIL rr_second_ce: ram=%b flash=%b required 0 1", bus.spi_ram_ce_n, bus.spi_flash_ce_n);
        end
        tick();
        tick();
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL rr_second_gnt: gnt0=%b gnt1=%b required 0 1", bus.gnt0, bus.gnt1);
        end
        bus.req1 = 1'b0;
        tick();
        wait_idle(30);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL rr_alternate: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        wait_idle(40);
    endtask

    task automatic test_no_preempt();
        int bad;
        int n;
        int s0;
        int d0;
        int d1;
        bus.req1 = 1'b1;
        bus.tgt1 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.spi_flash_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL np_own: gnt1=%b flash=%b required 1 0", bus.gnt1, bus.spi_flash_ce_n);
        end
        bus.req0 = 1'b1;
        bus.tgt0 = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.spi_flash_ce_n !== 1'b0 || bus.spi_ram_ce_n !== 1'b1 || bus.gnt0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL np_hold: %0d disturbed cycles required 0", bad);
        end
        // start0 from the non-owner while port 1 owns the bus
        s0 = eng_starts;
        d0 = done0_cnt;
        d1 = done1_cnt;
        bus.tx0    = 8'h77;
        bus.start0 = 1'b1;
        tick();
        bus.start0 = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.spi_txn_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || eng_starts != s0 || done0_cnt != d0 || done1_cnt != d1) begin
            failures++;
            $display("FAIL np_foreign_start: start_cycles=%0d eng_starts+%0d done+%0d/%0d required 0 0 0/0",
                     bad, eng_starts - s0, done0_cnt - d0, done1_cnt - d1);
        end
        bus.req1 = 1'b0;
        tick();
        n = 0;
        while (bus.gnt0 !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL np_handover: gnt0 after %0d cycles required 6", n);
        end
        // start1 while port 0 owns, then starts during release and idle
        s0 = eng_starts;
        d0 = done0_cnt;
        d1 = done1_cnt;
        bus.start1 = 1'b1;
        tick();
        bus.start1 = 1'b0;
        bus.req0 = 1'b0;
        tick();
        bus.start0 = 1'b1;
        bus.start1 = 1'b1;
        tick();
        bus.start0 = 1'b0;
        bus.start1 = 1'b0;
        wait_idle(30);
        bus.start0 = 1'b1;
        tick();
        bus.start0 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (eng_starts != s0 || done0_cnt != d0 || done1_cnt != d1 || bus.spi_txn_start !== 1'b0) begin
            failures++;
            $display("FAIL np_idle_start: eng_starts+%0d done+%0d/%0d start=%b required 0 0/0 0",
                     eng_starts - s0, done0_cnt - d0, done1_cnt - d1, bus.spi_txn_start);
        end
    endtask

    task automatic test_start_with_drop();
        bit got;
        int s0;
        int d0;
        bus.req0 = 1'b1;
        bus.tgt0 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL drop_gnt: gnt0=%b required 1", bus.gnt0);
        end
        s0 = eng_starts;
        d0 = done0_cnt;
        eng_rx     = 8'h3C;
        bus.tx0    = 8'h55;
        bus.start0 = 1'b1;
        bus.req0   = 1'b0;
        tick();
        bus.start0 = 1'b0;
        checks++;
        if (bus.spi_data_tx !== 8'h55 || bus.spi_txn_start !== 1'b1 || bus.gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL drop_start: tx=%h start=%b gnt0=%b required 55 1 1",
                     bus.spi_data_tx, bus.spi_txn_start, bus.gnt0);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            bus.start0 = ~bus.start0;
            tick();
            if (bus.done0 || bus.done1) got = 1'b1;
        end
        bus.start0 = 1'b0;
        checks++;
        if (!got || bus.done0 !== 1'b1 || bus.rx_data !== 8'h3C) begin
            failures++;
            $display("FAIL drop_done: seen=%0d done0=%b rx=%h required 1 1 3c", got, bus.done0, bus.rx_data);
        end
        checks++;
        if (bus.spi_flash_ce_n !== 1'b1 || bus.gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL drop_release: flash=%b gnt0=%b required 1 0", bus.spi_flash_ce_n, bus.gnt0);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (eng_starts - s0 != 1 || done0_cnt - d0 != 1 || bus.spi_txn_start !== 1'b0) begin
            failures++;
            $display("FAIL drop_single_byte: eng_starts+%0d done0+%0d start=%b required 1 1 0",
                     eng_starts - s0, done0_cnt - d0, bus.spi_txn_start);
        end
        wait_idle(30);
    endtask

    task automatic test_reset_mid_xfer();
        bit got;
        int n;
        bus.req1 = 1'b1;
        bus.tgt1 = 1'b1;
        tick();
        tick();
        tick();
        eng_rx     = 8'hEE;
        bus.tx1    = 8'hA5;
        bus.start1 = 1'b1;
        tick();
        bus.start1 = 1'b0;
        n = 0;
        while (state_dbg !== ST_XFER_WAIT && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (state_dbg !== ST_XFER_WAIT) begin
            failures++;
            $display("FAIL rst_reach_wait: state=%0d required %0d", state_dbg, ST_XFER_WAIT);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.spi_flash_ce_n, bus.spi_ram_ce_n} !== 2'b11 || {bus.gnt0, bus.gnt1} !== 2'b00 ||
            bus.spi_txn_start !== 1'b0 || bus.rx_data !== 8'h00 || bus.spi_data_tx !== 8'h00) begin
            failures++;
            $display("FAIL rst_abort: ce_n=%b gnt=%b start=%b rx=%h tx=%h required 11 00 0 00 00",
                     {bus.spi_flash_ce_n, bus.spi_ram_ce_n}, {bus.gnt0, bus.gnt1},
                     bus.spi_txn_start, bus.rx_data, bus.spi_data_tx);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.spi_ram_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL rst_regrant_ce: ram_ce_n=%b required 0", bus.spi_ram_ce_n);
        end
        tick();
        tick();
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL rst_regrant: gnt0=%b gnt1=%b required 0 1", bus.gnt0, bus.gnt1);
        end
        eng_rx     = 8'h81;
        bus.tx1    = 8'h12;
        bus.start1 = 1'b1;
        tick();
        bus.start1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (bus.done0 || bus.done1) got = 1'b1;
        end
        checks++;
        if (!got || bus.done1 !== 1'b1 || bus.done0 !== 1'b0 || bus.rx_data !== 8'h81) begin
            failures++;
            $display("FAIL rst_after_byte: seen=%0d done1=%b done0=%b rx=%h required 1 1 0 81",
                     got, bus.done1, bus.done0, bus.rx_data);
        end
        bus.req1 = 1'b0;
        tick();
        wait_idle(30);
    endtask

    task automatic test_soak();
        int c0;
        int dd;
        do_reset();
        c0 = eng_completes;
        dd = done0_cnt + done1_cnt;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 15) == 0) bus.req1 = ~bus.req1;
            if (!bus.req0) bus.tgt0 = 1'($urandom_range(0, 1));
            if (!bus.req1) bus.tgt1 = 1'($urandom_range(0, 1));
            bus.start0 = ($urandom_range(0, 3) == 0);
            bus.start1 = ($urandom_range(0, 3) == 0);
            bus.tx0    = 8'($urandom_range(0, 255));
            bus.tx1    = 8'($urandom_range(0, 255));
            eng_rx     = 8'($urandom_range(0, 255));
            tick();
        end
        drive_idle();
        tick();
        wait_idle(200);
        tick();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL soak_exclusion: %0d violations required 0", viol);
        end
        checks++;
        if ((done0_cnt + done1_cnt - dd) != (eng_completes - c0)) begin
            failures++;
            $display("FAIL soak_done_count: done pulses %0d engine completions %0d required equal",
                     done0_cnt + done1_cnt - dd, eng_completes - c0);
        end
        checks++;
        if (eng_completes - c0 < 20) begin
            failures++;
            $display("FAIL soak_activity: %0d bytes completed required at least 20", eng_completes - c0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst    = 1'b1;
        eng_rx = 8'h00;
        drive_idle();
        test_reset();
        test_single_session();
        test_round_robin();
        test_no_preempt();
        test_start_with_drop();
        test_reset_mid_xfer();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI byte engine and the flash/RAM chip selects between two requesters.
- Port 0 is the UART bootloader; port 1 is the CPU memory fetch/store controller.
- Grants whole CE-bracketed sessions (one or more bytes) with round-robin fairness, enforces CE setup and idle timing, and sequences the engine's start/done handshake for the current owner.
- Sits between the requesters and the SPI master, and owns spi_flash_ce_n and spi_ram_ce_n.

Parameters:
- CS_SETUP_CYCLES, 2, cycles CE is held low before the first byte may start (minimum 1).
- CS_IDLE_CYCLES, 4, cycles CE is held high after a session before any new grant (minimum 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0, req1  in  1  session request; hold high for the whole session; drop to end it
- tgt0, tgt1  in  1  session target; 0 = flash, 1 = RAM; sampled at grant
- gnt0, gnt1  out  1  requester owns the bus and CE is set up
- tx0, tx1  in  8  byte to send; sampled with start
- start0, start1  in  1  one-cycle pulse requesting a byte transfer
- done0, done1  out  1  one-cycle pulse when the owner's byte completes
- rx_data  out  8  received byte; valid with the done pulse; held until the next completion
- spi_data_tx  out  8  byte to the SPI engine
- spi_txn_start  out  1  engine start request
- spi_txn_done  in  1  engine idle/done level (high when idle)
- spi_data_rx  in  8  engine receive byte
- spi_flash_ce_n, spi_ram_ce_n  out  1  active-low chip selects

Behaviour:
- Reset (rst high at a clk edge) takes effect the next cycle:
  - state IDLE; gnt0/1, done0/1 and spi_txn_start are 0.
  - spi_data_tx and rx_data are 0x00; both CE_n are 1; last_winner is 1, so port 0 wins first; counters are 0.
  - Reset mid-session aborts immediately: CE goes high and any engine transfer is abandoned.
- States: IDLE, SETUP, OWNED, XFER_START, XFER_WAIT, RELEASE.
- IDLE:
  - Only req0 high: owner = 0. Only req1 high: owner = 1.
  - Both high: owner = the port that is not last_winner, and last_winner is updated.
  - On a grant, latch the owner's tgt, drive the matching CE_n low next cycle, and go to SETUP.
- SETUP: count CS_SETUP_CYCLES, then go to OWNED and assert gnt[owner].
  - req to gnt latency is 1 + CS_SETUP_CYCLES cycles.
- OWNED:
  - gnt[owner] stays high.
  - start[owner] latches tx[owner] into spi_data_tx, sets spi_txn_start next cycle, and goes to XFER_START.
  - start from the non-owner is ignored in every state.
  - req[owner] low with no start that cycle: drop gnt and CE next cycle, go to RELEASE.
  - If start and req drop occur in the same cycle, the start wins and the drop is handled after the byte.
- XFER_START: hold spi_txn_start high until spi_txn_done is sampled low, then drop it and go to XFER_WAIT.
- XFER_WAIT:
  - On spi_txn_done high, latch spi_data_rx into rx_data and pulse done[owner] for 1 cycle.
  - Then return to OWNED, or to RELEASE if req[owner] is already low.
  - start pulses during XFER_START or XFER_WAIT are ignored (not queued).
- RELEASE:
  - Both CE_n high and gnt low.
  - Count CS_IDLE_CYCLES, then go to IDLE. Requests arriving during RELEASE wait.
- No preemption: a higher-priority request never interrupts an owned session.
- Exactly one CE_n is low, and only in SETUP/OWNED/XFER_*; both are never low together.
- gnt0 and gnt1 are mutually exclusive.
- Counters are sized to hold max(CS_SETUP_CYCLES, CS_IDLE_CYCLES) and saturate-free: each is reloaded on state entry.
- rx_data is visible to both ports; consumers qualify it with their own done pulse.

Test Plan:
- req0 with tgt0=1 alone → spi_ram_ce_n low 1 cycle later; gnt0 high 3 cycles after req0 (defaults). start0 with tx0=0x9F → spi_data_tx=0x9F and spi_txn_start high until engine done drops. Engine returns 0xC2 → done0 pulses once with rx_data=0xC2.
- req0 and req1 rise in the same cycle after reset → port 0 granted first. Port 0 drops req → CE high for exactly 4 cycles, then port 1 granted. Repeat both simultaneously → port 0 granted (alternation).
- Port 1 owns the bus with tgt1=0; req0 rises mid-session → spi_flash_ce_n stays low, gnt0 stays 0 until port 1 releases and the 4 idle cycles elapse.
- req0 dropped in the same cycle as start0 (tx0=0x55) → byte 0x55 completes, done0 pulses, then CE goes high; no second transfer. Extra start0 pulses during XFER_WAIT produce no engine start.
- Assert rst during XFER_WAIT → next cycle both CE_n=1, gnt=0, spi_txn_start=0, rx_data=0x00. After rst drops, a new req1 is granted normally.
- start1 while port 0 is owner, and start0 while no grant → no spi_txn_start and no done pulses. Check gnt0&gnt1 and both CE_n low never occur over a 10k-cycle random req/start soak.
